// File: rtl/alu_seq_if.sv
// Request/response bundle between operand-read and writeback around alu_seq.
// slave is the ALU side; master is the issuing/consuming pipeline side.
interface alu_seq_if #(
    parameter int XLEN = 32
);
    logic            valid_i;
    logic            ready_o;
    logic [XLEN-1:0] operand_1_i;
    logic [XLEN-1:0] operand_2_i;
    logic [2:0]      funct3_i;
    logic [6:0]      funct7_i;
    logic            valid_o;
    logic            ready_i;
    logic [XLEN-1:0] result_o;
    logic            err_o;

    modport slave (
        input  valid_i, operand_1_i, operand_2_i, funct3_i, funct7_i, ready_i,
        output ready_o, valid_o, result_o, err_o
    );

    modport master (
        output valid_i, operand_1_i, operand_2_i, funct3_i, funct7_i, ready_i,
        input  ready_o, valid_o, result_o, err_o
    );
endinterface

// File: rtl/alu_seq.sv
// RV32I reg-reg ALU with iterative shifter: 1 cycle for non-shifts, 1+ceil(shamt/SHIFT_STEP) for shifts.
// Result held in DONE until ready_i; ready_o drops while busy and re-asserts in DONE when ready_i allows back-to-back.
module alu_seq #(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    alu_seq_if.slave  bus
);
    localparam int            SHW  = $clog2(XLEN);
    localparam logic [SHW:0]  STEP = (SHW+1)'(SHIFT_STEP);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t          r_state, w_state_nxt;
    logic [XLEN-1:0] r_result, w_result_nxt;
    logic [XLEN-1:0] r_work, w_work_nxt;
    logic            r_err, w_err_nxt;
    logic [SHW-1:0]  r_rem, w_rem_nxt;
    logic            r_left, w_left_nxt;
    logic            r_arith, w_arith_nxt;

    logic            w_accept;
    logic            w_sub;
    logic            w_legal;
    logic            w_is_shift;
    logic [SHW-1:0]  w_shamt;
    logic [XLEN-1:0] w_alu_res;
    logic [SHW:0]    w_step;
    logic [XLEN-1:0] w_shifted;
    logic [SHW-1:0]  w_rem_dec;

    assign bus.ready_o  = (r_state == IDLE) || ((r_state == DONE) && bus.ready_i);
    assign bus.valid_o  = (r_state == DONE);
    assign bus.result_o = r_result;
    assign bus.err_o    = r_err;

    assign w_accept   = bus.valid_i && bus.ready_o;
    assign w_shamt    = bus.operand_2_i[SHW-1:0];
    assign w_sub      = (bus.funct7_i == 7'h20);
    assign w_legal    = (bus.funct7_i == 7'h00) ||
                        (w_sub && ((bus.funct3_i == 3'b000) || (bus.funct3_i == 3'b101)));
    assign w_is_shift = w_legal && ((bus.funct3_i == 3'b001) || (bus.funct3_i == 3'b101));

    // Shift entries here only cover shamt==0; non-zero shifts go through SHIFT.
    always_comb begin
        w_alu_res = '0;
        if (w_legal) begin
            case (bus.funct3_i)
                3'b000:  w_alu_res = w_sub ? (bus.operand_1_i - bus.operand_2_i)
                                           : (bus.operand_1_i + bus.operand_2_i);
                3'b010:  w_alu_res = {{(XLEN-1){1'b0}},
                                      ($signed(bus.operand_1_i) < $signed(bus.operand_2_i))};
                3'b011:  w_alu_res = {{(XLEN-1){1'b0}}, (bus.operand_1_i < bus.operand_2_i)};
                3'b100:  w_alu_res = bus.operand_1_i ^ bus.operand_2_i;
                3'b110:  w_alu_res = bus.operand_1_i | bus.operand_2_i;
                3'b111:  w_alu_res = bus.operand_1_i & bus.operand_2_i;
                default: w_alu_res = bus.operand_1_i;
            endcase
        end
    end

    assign w_step    = ({1'b0, r_rem} > STEP) ? STEP : {1'b0, r_rem};
    assign w_rem_dec = r_rem - w_step[SHW-1:0];

    always_comb begin
        if (r_left)
            w_shifted = r_work << w_step;
        else if (r_arith)
            w_shifted = $unsigned($signed(r_work) >>> w_step);
        else
            w_shifted = r_work >> w_step;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_result_nxt = r_result;
        w_err_nxt    = r_err;
        w_work_nxt   = r_work;
        w_rem_nxt    = r_rem;
        w_left_nxt   = r_left;
        w_arith_nxt  = r_arith;
        case (r_state)
            IDLE, DONE: begin
                if (w_accept) begin
                    if (w_is_shift && (w_shamt != '0)) begin
                        w_state_nxt = SHIFT;
                        w_work_nxt  = bus.operand_1_i;
                        w_rem_nxt   = w_shamt;
                        w_left_nxt  = (bus.funct3_i == 3'b001);
                        w_arith_nxt = w_sub;
                    end else begin
                        w_state_nxt  = DONE;
                        w_result_nxt = w_alu_res;
                        w_err_nxt    = ~w_legal;
                    end
                end else if (r_state == DONE && bus.ready_i) begin
                    w_state_nxt = IDLE;
                end
            end
            SHIFT: begin
                w_work_nxt = w_shifted;
                w_rem_nxt  = w_rem_dec;
                if (w_rem_dec == '0) begin
                    w_state_nxt  = DONE;
                    w_result_nxt = w_shifted;
                    w_err_nxt    = 1'b0;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= IDLE;
            r_result <= '0;
            r_err    <= 1'b0;
            r_work   <= '0;
            r_rem    <= '0;
            r_left   <= 1'b0;
            r_arith  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_result <= w_result_nxt;
            r_err    <= w_err_nxt;
            r_work   <= w_work_nxt;
            r_rem    <= w_rem_nxt;
            r_left   <= w_left_nxt;
            r_arith  <= w_arith_nxt;
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: one DUT with SHIFT_STEP=1, a second with SHIFT_STEP=4 for latency scaling.
module tb_alu_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_seq_if #(.XLEN(32)) bus ();
    alu_seq_if #(.XLEN(32)) bus_b ();

    alu_seq #(.XLEN(32), .SHIFT_STEP(1)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));
    alu_seq #(.XLEN(32), .SHIFT_STEP(4)) dut_b (.clk_i(clk), .rst_ni(rst_n), .bus(bus_b));

    int errors = 0;
    int checks = 0;
    logic [31:0] res;
    logic        e;
    int          lat;

    // Caller is at posedge+1 with the DUT able to accept; returns once valid_o is seen.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                          input logic [6:0] f7, output logic [31:0] r, output logic er, output int l);
        bus.valid_i = 1'b1; bus.operand_1_i = a; bus.operand_2_i = b;
        bus.funct3_i = f3; bus.funct7_i = f7;
        @(posedge clk); #1;
        bus.valid_i = 1'b0; bus.operand_1_i = 32'hDEADBEEF; bus.operand_2_i = 32'h5A5A5A5A;
        bus.funct3_i = 3'b111; bus.funct7_i = 7'h7F;
        l = 1;
        while (!bus.valid_o && l < 200) begin
            @(posedge clk); #1;
            l++;
        end
        r = bus.result_o; er = bus.err_o;
    endtask

    task automatic retire();
        bus.ready_i = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL retire valid_o got %b exp 0", bus.valid_o); end
    endtask

    task automatic test_reset();
        #2;
        checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", bus.valid_o); end
        checks++; if (bus.result_o !== 32'h0) begin errors++; $display("FAIL rst_result got %h exp 0", bus.result_o); end
        checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", bus.err_o); end
        checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", bus.ready_o); end
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_add_sub();
        run_op(32'd5, 32'd7, 3'b000, 7'h00, res, e, lat);
        checks++; if (res !== 32'h0000000C) begin errors++; $display("FAIL add_res got %h exp 0000000c", res); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL add_err got %b exp 0", e); end
        checks++; if (lat !== 1) begin errors++; $display("FAIL add_lat got %0d exp 1", lat); end
        retire();
        run_op(32'd3, 32'd5, 3'b000, 7'h20, res, e, lat);
        checks++; if (res !== 32'hFFFFFFFE) begin errors++; $display("FAIL sub_res got %h exp fffffffe", res); end
        retire();
    endtask

    task automatic test_compare();
        run_op(32'hFFFFFFFF, 32'd1, 3'b010, 7'h00, res, e, lat);
        checks++; if (res !== 32'd1) begin errors++; $display("FAIL slt_neg got %h exp 1", res); end
        retire();
        run_op(32'hFFFFFFFF, 32'd1, 3'b011, 7'h00, res, e, lat);
        checks++; if (res !== 32'd0) begin errors++; $display("FAIL sltu got %h exp 0", res); end
        retire();
        run_op(32'd9, 32'd9, 3'b010, 7'h00, res, e, lat);
        checks++; if (res !== 32'd0) begin errors++; $display("FAIL slt_eq got %h exp 0", res); end
        retire();
    endtask

    task automatic test_logic();
        run_op(32'hF0F0F0F0, 32'hFF00FF00, 3'b100, 7'h00, res, e, lat);
        checks++; if (res !== 32'h0FF00FF0) begin errors++; $display("FAIL xor got %h exp 0ff00ff0", res); end
        retire();
        run_op(32'hF0F0F0F0, 32'hFF00FF00, 3'b110, 7'h00, res, e, lat);
        checks++; if (res !== 32'hFFF0FFF0) begin errors++; $display("FAIL or got %h exp fff0fff0", res); end
        retire();
        run_op(32'hF0F0F0F0, 32'hFF00FF00, 3'b111, 7'h00, res, e, lat);
        checks++; if (res !== 32'hF000F000) begin errors++; $display("FAIL and got %h exp f000f000", res); end
        retire();
    endtask

    task automatic test_shift();
        run_op(32'h80000000, 32'd31, 3'b101, 7'h20, res, e, lat);
        checks++; if (res !== 32'hFFFFFFFF) begin errors++; $display("FAIL sra31_res got %h exp ffffffff", res); end
        checks++; if (lat !== 32) begin errors++; $display("FAIL sra31_lat got %0d exp 32", lat); end
        retire();
        run_op(32'h80000000, 32'd31, 3'b101, 7'h00, res, e, lat);
        checks++; if (res !== 32'h00000001) begin errors++; $display("FAIL srl31_res got %h exp 00000001", res); end
        retire();
        run_op(32'h80000000, 32'd4, 3'b101, 7'h20, res, e, lat);
        checks++; if (res !== 32'hF8000000) begin errors++; $display("FAIL sra4_res got %h exp f8000000", res); end
        checks++; if (lat !== 5) begin errors++; $display("FAIL sra4_lat got %0d exp 5", lat); end
        retire();
        run_op(32'h12345678, 32'd0, 3'b001, 7'h00, res, e, lat);
        checks++; if (res !== 32'h12345678) begin errors++; $display("FAIL sll0_res got %h exp 12345678", res); end
        checks++; if (lat !== 1) begin errors++; $display("FAIL sll0_lat got %0d exp 1", lat); end
        retire();
        run_op(32'h00000001, 32'h00000021, 3'b001, 7'h00, res, e, lat);
        checks++; if (res !== 32'h00000002) begin errors++; $display("FAIL sll_mask_res got %h exp 00000002", res); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL sll_mask_lat got %0d exp 2", lat); end
        retire();
    endtask

    task automatic test_shift_step4();
        int l;
        bus_b.valid_i = 1'b1; bus_b.operand_1_i = 32'h80000000; bus_b.operand_2_i = 32'd31;
        bus_b.funct3_i = 3'b101; bus_b.funct7_i = 7'h20;
        @(posedge clk); #1;
        bus_b.valid_i = 1'b0; bus_b.operand_1_i = 32'h0;
        l = 1;
        while (!bus_b.valid_o && l < 200) begin @(posedge clk); #1; l++; end
        checks++; if (bus_b.result_o !== 32'hFFFFFFFF) begin errors++; $display("FAIL s4_sra_res got %h exp ffffffff", bus_b.result_o); end
        checks++; if (l !== 9) begin errors++; $display("FAIL s4_sra_lat got %0d exp 9", l); end
        bus_b.valid_i = 1'b1; bus_b.operand_1_i = 32'h1; bus_b.operand_2_i = 32'd5;
        bus_b.funct3_i = 3'b001; bus_b.funct7_i = 7'h00;
        @(posedge clk); #1;
        bus_b.valid_i = 1'b0;
        l = 1;
        while (!bus_b.valid_o && l < 200) begin @(posedge clk); #1; l++; end
        checks++; if (bus_b.result_o !== 32'h00000020) begin errors++; $display("FAIL s4_sll_res got %h exp 00000020", bus_b.result_o); end
        checks++; if (l !== 3) begin errors++; $display("FAIL s4_sll_lat got %0d exp 3", l); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        bus.ready_i = 1'b0;
        run_op(32'h10, 32'h20, 3'b000, 7'h00, res, e, lat);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++; if (bus.valid_o !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got %b exp 1", i, bus.valid_o); end
            checks++; if (bus.result_o !== 32'h30) begin errors++; $display("FAIL bp_result[%0d] got %h exp 00000030", i, bus.result_o); end
            checks++; if (bus.ready_o !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d] got %b exp 0", i, bus.ready_o); end
        end
        bus.ready_i = 1'b1;
        bus.valid_i = 1'b1; bus.operand_1_i = 32'hAAAA5555; bus.operand_2_i = 32'h0000FFFF;
        bus.funct3_i = 3'b100; bus.funct7_i = 7'h00;
        #1;
        checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b exp 1", bus.ready_o); end
        @(posedge clk); #1;
        bus.valid_i = 1'b0;
        checks++; if (bus.valid_o !== 1'b1) begin errors++; $display("FAIL b2b_valid got %b exp 1", bus.valid_o); end
        checks++; if (bus.result_o !== 32'hAAAAAAAA) begin errors++; $display("FAIL b2b_result got %h exp aaaaaaaa", bus.result_o); end
        retire();
    endtask

    task automatic test_illegal();
        run_op(32'd5, 32'd7, 3'b000, 7'h01, res, e, lat);
        checks++; if (res !== 32'h0) begin errors++; $display("FAIL ill_res got %h exp 0", res); end
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL ill_err got %b exp 1", e); end
        checks++; if (lat !== 1) begin errors++; $display("FAIL ill_lat got %0d exp 1", lat); end
        retire();
        run_op(32'd5, 32'd7, 3'b100, 7'h20, res, e, lat);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL ill_sub_xor_err got %b exp 1", e); end
        retire();
        run_op(32'd1, 32'd1, 3'b000, 7'h00, res, e, lat);
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL ill_clear_err got %b exp 0", e); end
        checks++; if (res !== 32'd2) begin errors++; $display("FAIL ill_clear_res got %h exp 2", res); end
        retire();
    endtask

    task automatic test_reset_mid_shift();
        int stale;
        bus.valid_i = 1'b1; bus.operand_1_i = 32'h80000000; bus.operand_2_i = 32'd31;
        bus.funct3_i = 3'b101; bus.funct7_i = 7'h20;
        @(posedge clk); #1;
        bus.valid_i = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b exp 0", bus.valid_o); end
        checks++; if (bus.result_o !== 32'h0) begin errors++; $display("FAIL mid_rst_result got %h exp 0", bus.result_o); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL mid_rst_ready got %b exp 1", bus.ready_o); end
        stale = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.valid_o !== 1'b0) stale++;
        end
        checks++; if (stale !== 0) begin errors++; $display("FAIL mid_rst_stale got %0d exp 0", stale); end
    endtask

    initial begin
        bus.valid_i = 1'b0; bus.ready_i = 1'b1;
        bus.operand_1_i = '0; bus.operand_2_i = '0; bus.funct3_i = '0; bus.funct7_i = '0;
        bus_b.valid_i = 1'b0; bus_b.ready_i = 1'b1;
        bus_b.operand_1_i = '0; bus_b.operand_2_i = '0; bus_b.funct3_i = '0; bus_b.funct7_i = '0;
        test_reset();
        test_add_sub();
        test_compare();
        test_logic();
        test_shift();
        test_shift_step4();
        test_back_to_back();
        test_illegal();
        test_reset_mid_shift();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
